// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode block.
//   fsm_state_t : fetch sequencer states
//   OP_*        : primary opcodes accepted by the decoder
//   XO_*        : extended opcodes recognised under OP_X (opcode 31)
package instr_fetch_decode_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE
    } fsm_state_t;

    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_ADDIS = 6'd15;
    localparam logic [5:0] OP_B     = 6'd18;
    localparam logic [5:0] OP_XL    = 6'd19;
    localparam logic [5:0] OP_ORI   = 6'd24;
    localparam logic [5:0] OP_XORI  = 6'd26;
    localparam logic [5:0] OP_ANDI  = 6'd28;
    localparam logic [5:0] OP_X     = 6'd31;
    localparam logic [5:0] OP_LWZ   = 6'd32;
    localparam logic [5:0] OP_LBZ   = 6'd34;
    localparam logic [5:0] OP_STW   = 6'd36;
    localparam logic [5:0] OP_STWU  = 6'd37;
    localparam logic [5:0] OP_STB   = 6'd38;
    localparam logic [5:0] OP_LHZ   = 6'd40;
    localparam logic [5:0] OP_LHA   = 6'd42;
    localparam logic [5:0] OP_STH   = 6'd44;
    localparam logic [5:0] OP_LD    = 6'd58;
    localparam logic [5:0] OP_STD   = 6'd62;

    localparam logic [9:0] XO_ADD   = 10'd266;
    localparam logic [9:0] XO_SUBF  = 10'd40;
    localparam logic [9:0] XO_AND   = 10'd28;
    localparam logic [9:0] XO_OR    = 10'd444;
    localparam logic [9:0] XO_XOR   = 10'd316;
    localparam logic [9:0] XO_NAND  = 10'd476;
    localparam logic [9:0] XO_EXTSW = 10'd986;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction memory bus.
//   req   : fetch request, held until ack
//   addr  : word-aligned fetch address, stable while req=1
//   ack   : one-cycle strobe, rdata valid
//   rdata : instruction word
// master = fetch unit, slave = instruction memory.
interface instr_fetch_decode_if #(
    parameter int unsigned AW = 64
);
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [31:0]   rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_field_decode.sv
// Combinational field extraction and legality check of one 32-bit instruction.
//   instr   : instruction word (bit 31 = opcode MSB)
//   opcode..bi : decoded fields
//   illegal : opcode (or opcode-31 extended opcode) outside the supported set
module instr_field_decode
    import instr_fetch_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rt,
    output logic [4:0]  ra,
    output logic [4:0]  rb,
    output logic [9:0]  xox,
    output logic [8:0]  xoxo,
    output logic        rc,
    output logic        aa,
    output logic [15:0] si,
    output logic [13:0] ds,
    output logic [1:0]  xods,
    output logic [23:0] li,
    output logic [4:0]  bo,
    output logic [4:0]  bi,
    output logic        illegal
);
    logic xo_arith;

    assign opcode = instr[31:26];
    assign rt     = instr[25:21];
    assign bo     = instr[25:21];
    assign ra     = instr[20:16];
    assign bi     = instr[20:16];
    assign rb     = instr[15:11];
    assign xox    = instr[10:1];
    assign rc     = instr[0];
    assign aa     = instr[1];
    assign si     = instr[15:0];
    assign ds     = instr[15:2];
    assign xods   = instr[1:0];
    assign li     = instr[25:2];

    // XO-form arithmetic carries OE in bit 10, so only the 9-bit field identifies it.
    assign xo_arith = (opcode == OP_X) &&
                      ((instr[9:1] == XO_ADD[8:0]) || (instr[9:1] == XO_SUBF[8:0]));
    assign xoxo     = xo_arith ? instr[9:1] : '0;

    always_comb begin
        illegal = 1'b1;
        case (opcode)
            OP_ADDI, OP_ADDIS, OP_B, OP_XL, OP_ORI, OP_XORI, OP_ANDI,
            OP_LWZ, OP_LBZ, OP_STW, OP_STWU, OP_STB, OP_LHZ, OP_LHA,
            OP_STH, OP_LD, OP_STD: illegal = 1'b0;
            OP_X: illegal = !((xox == XO_AND) || (xox == XO_XOR) || (xox == XO_OR) ||
                              (xox == XO_NAND) || (xox == XO_EXTSW) || (xoxo != '0));
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch sequencer plus decode of the fetched word.
//   clk, rst      : clock, synchronous active-high reset
//   imem          : instruction memory bus (master side)
//   redirect      : one-cycle branch-taken strobe, target on redirect_pc
//   dec_valid/dec_ready : issue handshake toward execute
//   dec_pc        : address of the issued instruction
//   opcode..bi    : decoded fields of the issued instruction
//   dec_illegal   : issued instruction is not in the supported set
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned IMEM_AW  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_decode_if.master imem,
    input  logic                 redirect,
    input  logic [IMEM_AW-1:0]   redirect_pc,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [IMEM_AW-1:0]   dec_pc,
    output logic [5:0]           opcode,
    output logic [4:0]           rt,
    output logic [4:0]           ra,
    output logic [4:0]           rb,
    output logic [9:0]           xox,
    output logic [8:0]           xoxo,
    output logic                 rc,
    output logic                 aa,
    output logic [15:0]          si,
    output logic [13:0]          ds,
    output logic [1:0]           xods,
    output logic [23:0]          li,
    output logic [4:0]           bo,
    output logic [4:0]           bi,
    output logic                 dec_illegal
);
    fsm_state_t         state_q;
    logic [IMEM_AW-1:0] pc_q;
    logic [IMEM_AW-1:0] addr_q;
    logic               req_q;
    logic               valid_q;
    logic [31:0]        ir_q;
    logic               pend_q;
    logic [IMEM_AW-1:0] pend_pc_q;
    logic [IMEM_AW-1:0] target;
    logic               illegal;

    assign target = redirect_pc & ~IMEM_AW'(3);

    // The request is registered when leaving FETCH, so a redirect in FETCH never
    // exposes a request to the memory that would later have to be cancelled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC[IMEM_AW-1:0];
            addr_q    <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            ir_q      <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (redirect) begin
                        pc_q <= target;
                    end else begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.ack) begin
                        req_q <= 1'b0;
                        if (redirect || pend_q) begin
                            // Word belongs to the abandoned path: drop it and refetch.
                            pc_q    <= redirect ? target : pend_pc_q;
                            pend_q  <= 1'b0;
                            state_q <= FETCH;
                        end else begin
                            ir_q    <= imem.rdata;
                            valid_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end else if (redirect) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= target;
                    end
                end
                ISSUE: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= target;
                        state_q <= FETCH;
                    end else if (dec_ready) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_q + IMEM_AW'(4);
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = addr_q;
    assign dec_valid = valid_q;
    assign dec_pc    = pc_q;
    // Fields follow the instruction register; illegal only means something while issuing.
    assign dec_illegal = valid_q & illegal;

    instr_field_decode u_field_decode (
        .instr   (ir_q),
        .opcode  (opcode),
        .rt      (rt),
        .ra      (ra),
        .rb      (rb),
        .xox     (xox),
        .xoxo    (xoxo),
        .rc      (rc),
        .aa      (aa),
        .si      (si),
        .ds      (ds),
        .xods    (xods),
        .li      (li),
        .bo      (bo),
        .bi      (bi),
        .illegal (illegal)
    );
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode.
module tb_instr_fetch_decode;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [AW-1:0] dec_pc;
    logic [5:0]    opcode;
    logic [4:0]    rt, ra, rb, bo, bi;
    logic [9:0]    xox;
    logic [8:0]    xoxo;
    logic          rc, aa;
    logic [15:0]   si;
    logic [13:0]   ds;
    logic [1:0]    xods;
    logic [23:0]   li;
    logic          dec_illegal;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_cnt = 0;
    int mem_wait = 0;
    bit mem_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_decode_if #(.AW(AW)) bus ();

    instr_fetch_decode #(.RESET_PC(64'h0), .IMEM_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .opcode      (opcode),
        .rt          (rt),
        .ra          (ra),
        .rb          (rb),
        .xox         (xox),
        .xoxo        (xoxo),
        .rc          (rc),
        .aa          (aa),
        .si          (si),
        .ds          (ds),
        .xods        (xods),
        .li          (li),
        .bo          (bo),
        .bi          (bi),
        .dec_illegal (dec_illegal)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        case (a)
            16'h0000: return 32'h7C221A14;  // add r1,r2,r3
            16'h0004: return 32'h38220005;  // addi r1,r2,5
            16'h0008: return 32'h7C221B78;  // or
            16'h000C: return 32'h04000000;  // opcode 1
            16'h0010: return 32'h3860FFFF;  // addi r3,0,-1
            16'h0014: return 32'h48000100;  // b +0x100
            default:  return 32'h60000000;  // ori 0,0,0
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle; inputs change on the falling edge. With mem_en the memory acks
    // mem_wait cycles after it first sees a request (0 = same cycle).
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mem_en) begin
            if (bus.req) begin
                mem_cnt++;
                if (mem_cnt > mem_wait) begin
                    bus.ack   = 1'b1;
                    bus.rdata = mem_word(bus.addr);
                    mem_cnt   = 0;
                end else begin
                    bus.ack = 1'b0;
                end
            end else begin
                mem_cnt = 0;
                bus.ack = 1'b0;
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dec_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, dec_valid, 1);
    endtask

    task automatic do_reset(input bit use_mem);
        rst      = 1'b1;
        mem_en   = 1'b0;
        bus.ack  = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        mem_en = use_mem;
        rst    = 1'b0;
    endtask

    initial begin
        int t0;
        rst         = 1'b1;
        bus.ack     = 1'b0;
        bus.rdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_req", bus.req, 0);
        check("rst_valid", dec_valid, 0);
        check("rst_illegal", dec_illegal, 0);
        check("rst_pc", dec_pc, 0);
        check("rst_fields_a", {opcode, rt, ra, rb, xox, xoxo, rc, aa}, 0);
        check("rst_fields_b", {si, ds, xods, li, bo, bi}, 0);

        // Zero-wait program, dec_ready high
        mem_en = 1'b1;
        rst    = 1'b0;
        wait_valid("i0_valid");
        t0 = cyc;
        check("i0_pc", dec_pc, 16'h0000);
        check("i0_opcode", opcode, 31);
        check("i0_xoxo", xoxo, 266);
        check("i0_regs", {rt, ra, rb}, {5'd1, 5'd2, 5'd3});
        check("i0_bo_bi", {bo, bi}, {5'd1, 5'd2});
        check("i0_illegal", dec_illegal, 0);
        tick();
        wait_valid("i1_valid");
        check("i1_period", cyc - t0, 3);
        check("i1_pc", dec_pc, 16'h0004);
        check("i1_opcode", opcode, 14);
        check("i1_si", si, 5);
        check("i1_xoxo", xoxo, 0);
        check("i1_ds_xods", {ds, xods}, {14'd1, 2'd1});
        tick();
        wait_valid("i2_valid");
        check("i2_pc", dec_pc, 16'h0008);
        check("i2_opcode", opcode, 31);
        check("i2_xox", xox, 444);
        check("i2_xoxo", xoxo, 0);
        check("i2_illegal", dec_illegal, 0);
        tick();
        wait_valid("i3_valid");
        check("i3_opcode", opcode, 1);
        check("i3_illegal", dec_illegal, 1);
        tick();

        // Back-pressure: everything holds while dec_ready is low
        dec_ready = 1'b0;
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid_hold", dec_valid, 1);
            check("stall_pc_hold", dec_pc, 16'h0010);
            check("stall_fields_hold", {opcode, si}, {6'd14, 16'hFFFF});
            check("stall_no_req", bus.req, 0);
        end
        dec_ready = 1'b1;
        tick();
        wait_valid("b_valid");
        check("b_pc", dec_pc, 16'h0014);
        check("b_opcode", opcode, 18);
        check("b_li_aa", {li, aa}, {24'h40, 1'b0});
        check("b_illegal", dec_illegal, 0);
        tick();

        // Redirect coincident with the issue handshake
        wait_valid("r0_valid");
        check("r0_pc", dec_pc, 16'h0018);
        redirect    = 1'b1;
        redirect_pc = 16'h0203;
        tick();
        redirect = 1'b0;
        check("r0_dropped", dec_valid, 0);
        tick();
        check("r0_req", bus.req, 1);
        check("r0_addr", bus.addr, 16'h0200);
        wait_valid("r1_valid");
        check("r1_pc", dec_pc, 16'h0200);
        check("r1_opcode", opcode, 24);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        wait_valid("wrap0_valid");
        check("wrap0_pc", dec_pc, 16'hFFFC);
        tick();
        wait_valid("wrap1_valid");
        check("wrap1_pc", dec_pc, 16'h0000);
        check("wrap1_opcode", opcode, 31);
        tick();

        // Redirect during WAIT, ack three cycles later
        do_reset(1'b0);
        tick();                         // FETCH
        tick();                         // WAIT
        check("rw_req", bus.req, 1);
        check("rw_addr", bus.addr, 16'h0000);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("rw_hold_req", bus.req, 1);
        check("rw_hold_addr", bus.addr, 16'h0000);
        check("rw_no_valid0", dec_valid, 0);
        tick();
        check("rw_no_valid1", dec_valid, 0);
        tick();
        bus.ack   = 1'b1;
        bus.rdata = 32'h38220005;
        tick();
        bus.ack = 1'b0;
        check("rw_discard_valid", dec_valid, 0);
        check("rw_discard_req", bus.req, 0);
        tick();
        check("rw_new_req", bus.req, 1);
        check("rw_new_addr", bus.addr, 16'h0100);
        check("rw_no_valid2", dec_valid, 0);
        bus.ack   = 1'b1;
        bus.rdata = 32'h38220009;
        tick();
        bus.ack = 1'b0;
        check("rw_issue_valid", dec_valid, 1);
        check("rw_issue_pc", dec_pc, 16'h0100);
        check("rw_issue_si", si, 9);
        tick();

        // Reset mid-WAIT, late ack in IDLE and FETCH
        do_reset(1'b0);
        tick();                         // FETCH
        tick();                         // WAIT
        check("rm_req", bus.req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_req_cleared", bus.req, 0);
        check("rm_valid_cleared", dec_valid, 0);
        bus.ack   = 1'b1;
        bus.rdata = 32'h38220005;
        tick();                         // FETCH, ack still high
        bus.rdata = 32'h3822000F;
        check("rm_late_ack_idle", dec_valid, 0);
        tick();                         // WAIT
        check("rm_late_ack_fetch", dec_valid, 0);
        check("rm_first_req", bus.req, 1);
        check("rm_first_addr", bus.addr, 16'h0000);
        bus.rdata = 32'h38220007;
        tick();
        bus.ack = 1'b0;
        check("rm_issue_valid", dec_valid, 1);
        check("rm_issue_pc", dec_pc, 16'h0000);
        check("rm_issue_si", si, 7);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
